// File: rtl/genaxis_ctrl_regs.sv
// genaxis_ctrl_regs: control/status register bank for the AXI-Stream generator.
// Latency: every rd/wr request is acked exactly one cycle later with registered ack/data.
// Backpressure: none; the wait outputs are tied low and an ack can never stall.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   reg_wr_* / reg_rd_*            register strobes from the AXI-Lite adapters
//   gen_enable, gen_start          core enable level and one-cycle start pulse
//   gen_pkt_len, gen_pkt_num       run configuration
//   gen_busy, gen_done, gen_pkt_sent  core status and event inputs
module genaxis_ctrl_regs #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [31:0] ID_VALUE   = 32'h47454E41
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic [STRB_WIDTH-1:0] reg_wr_strb,
  input  logic                  reg_wr_en,
  output logic                  reg_wr_wait,
  output logic                  reg_wr_ack,
  input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic                  reg_rd_en,
  output logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  reg_rd_wait,
  output logic                  reg_rd_ack,
  output logic                  gen_enable,
  output logic                  gen_start,
  output logic [15:0]           gen_pkt_len,
  output logic [31:0]           gen_pkt_num,
  input  logic                  gen_busy,
  input  logic                  gen_done,
  input  logic                  gen_pkt_sent
);

  localparam logic [3:0] A_CTRL    = 4'h0;
  localparam logic [3:0] A_STATUS  = 4'h1;
  localparam logic [3:0] A_PKT_LEN = 4'h2;
  localparam logic [3:0] A_PKT_NUM = 4'h3;
  localparam logic [3:0] A_TX_CNT  = 4'h4;
  localparam logic [3:0] A_ID      = 4'h5;

  logic                  wr_ack_q, rd_ack_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  enable_q, enable_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  start_err_q, start_err_d;
  logic [15:0]           pkt_len_q, pkt_len_d;
  logic [31:0]           pkt_num_q, pkt_num_d;
  logic [31:0]           tx_cnt_q, tx_cnt_d;
  logic [15:0]           len_merged;

  logic                  wr_fire, rd_fire;
  logic [3:0]            wr_idx, rd_idx;
  logic                  unused_addr;

  // A request is served only while no ack is outstanding, so a held
  // enable produces exactly one ack.
  assign wr_fire = reg_wr_en & ~wr_ack_q;
  assign rd_fire = reg_rd_en & ~rd_ack_q;
  assign wr_idx  = reg_wr_addr[5:2];
  assign rd_idx  = reg_rd_addr[5:2];

  assign unused_addr = ^{reg_wr_addr[1:0], reg_wr_addr[ADDR_WIDTH-1:6],
                         reg_rd_addr[1:0], reg_rd_addr[ADDR_WIDTH-1:6]};

  // Next-state of the register file. Ordering encodes the event priorities:
  // cnt_clr is applied after the pkt_sent increment, gen_done after the W1C.
  always_comb begin
    enable_d    = enable_q;
    start_d     = 1'b0;
    done_d      = done_q;
    start_err_d = start_err_q;
    pkt_len_d   = pkt_len_q;
    pkt_num_d   = pkt_num_q;
    tx_cnt_d    = tx_cnt_q;
    len_merged  = pkt_len_q;

    if (gen_pkt_sent && (tx_cnt_q != 32'hFFFF_FFFF)) begin
      tx_cnt_d = tx_cnt_q + 32'd1;
    end

    if (wr_fire) begin
      case (wr_idx)
        A_CTRL: begin
          if (reg_wr_strb[0]) begin
            enable_d = reg_wr_data[0];
            // Start is judged against the enable value this write leaves behind.
            if (reg_wr_data[1]) begin
              if (reg_wr_data[0] && !gen_busy) start_d = 1'b1;
              else                             start_err_d = 1'b1;
            end
            if (reg_wr_data[2]) tx_cnt_d = '0;
          end
        end
        A_STATUS: begin
          if (reg_wr_strb[0]) begin
            if (reg_wr_data[1]) done_d      = 1'b0;
            if (reg_wr_data[2]) start_err_d = 1'b0;
          end
        end
        A_PKT_LEN: begin
          if (reg_wr_strb[0]) len_merged[7:0]  = reg_wr_data[7:0];
          if (reg_wr_strb[1]) len_merged[15:8] = reg_wr_data[15:8];
          // A zero-length packet is meaningless to the core; clamp to one beat.
          pkt_len_d = (len_merged == 16'd0) ? 16'd1 : len_merged;
        end
        A_PKT_NUM: begin
          for (int b = 0; b < 4; b++) begin
            if (reg_wr_strb[b]) pkt_num_d[8*b +: 8] = reg_wr_data[8*b +: 8];
          end
        end
        default: ;
      endcase
    end

    if (gen_done) done_d = 1'b1;
  end

  // Read mux samples the current register state, so same-cycle updates are not visible.
  always_comb begin
    rd_data_d = '0;
    if (rd_fire) begin
      case (rd_idx)
        A_CTRL:    rd_data_d = {31'd0, enable_q};
        A_STATUS:  rd_data_d = {29'd0, start_err_q, done_q, gen_busy};
        A_PKT_LEN: rd_data_d = {16'd0, pkt_len_q};
        A_PKT_NUM: rd_data_d = pkt_num_q;
        A_TX_CNT:  rd_data_d = tx_cnt_q;
        A_ID:      rd_data_d = ID_VALUE;
        default:   rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
      enable_q    <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      pkt_len_q   <= 16'd64;
      pkt_num_q   <= 32'd1;
      tx_cnt_q    <= '0;
    end else begin
      wr_ack_q    <= wr_fire;
      rd_ack_q    <= rd_fire;
      rd_data_q   <= rd_data_d;
      enable_q    <= enable_d;
      start_q     <= start_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      pkt_len_q   <= pkt_len_d;
      pkt_num_q   <= pkt_num_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  assign reg_wr_wait = 1'b0;
  assign reg_rd_wait = 1'b0;
  assign reg_wr_ack  = wr_ack_q;
  assign reg_rd_ack  = rd_ack_q;
  assign reg_rd_data = rd_data_q;
  assign gen_enable  = enable_q;
  assign gen_start   = start_q;
  assign gen_pkt_len = pkt_len_q;
  assign gen_pkt_num = pkt_num_q;

endmodule

// File: tb/tb_genaxis_ctrl_regs.sv
module tb_genaxis_ctrl_regs;

  localparam logic [31:0] ID = 32'h47454E41;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  reg_wr_addr = '0;
  logic [31:0] reg_wr_data = '0;
  logic [3:0]  reg_wr_strb = '0;
  logic        reg_wr_en = 1'b0;
  logic        reg_wr_wait, reg_wr_ack;
  logic [7:0]  reg_rd_addr = '0;
  logic        reg_rd_en = 1'b0;
  logic [31:0] reg_rd_data;
  logic        reg_rd_wait, reg_rd_ack;
  logic        gen_enable, gen_start;
  logic [15:0] gen_pkt_len;
  logic [31:0] gen_pkt_num;
  logic        gen_busy = 1'b0;
  logic        gen_done = 1'b0;
  logic        gen_pkt_sent = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model of the architectural register state.
  bit          m_en, m_done, m_serr;
  logic [15:0] m_len;
  logic [31:0] m_num;
  longint      m_cnt;

  // Observations and expectations of the last transaction.
  bit          o_wack, o_rack, o_start, o_quiet;
  logic [31:0] o_rdat;
  logic [31:0] x_rdat;
  bit          x_start;

  always #5 clk = ~clk;

  genaxis_ctrl_regs dut (
    .clk(clk), .rst(rst),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack),
    .gen_enable(gen_enable), .gen_start(gen_start),
    .gen_pkt_len(gen_pkt_len), .gen_pkt_num(gen_pkt_num),
    .gen_busy(gen_busy), .gen_done(gen_done), .gen_pkt_sent(gen_pkt_sent)
  );

  function automatic void m_reset();
    m_en = 0; m_done = 0; m_serr = 0; m_len = 16'd64; m_num = 32'd1; m_cnt = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    case (idx)
      4'd0:    return {31'd0, m_en};
      4'd1:    return {29'd0, m_serr, m_done, gen_busy};
      4'd2:    return {16'd0, m_len};
      4'd3:    return m_num;
      4'd4:    return m_cnt[31:0];
      4'd5:    return ID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_write(input logic [7:0] addr, input logic [31:0] data,
                                  input logic [3:0] strb);
    logic [31:0] mask;
    logic [15:0] nl;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    case (addr[5:2])
      4'd0: if (strb[0]) begin
        m_en = data[0];
        if (data[1]) begin
          if (m_en && !gen_busy) x_start = 1'b1;
          else                   m_serr  = 1'b1;
        end
        if (data[2]) m_cnt = 0;
      end
      4'd1: if (strb[0]) begin
        if (data[1]) m_done = 1'b0;
        if (data[2]) m_serr = 1'b0;
      end
      4'd2: begin
        nl = (m_len & ~mask[15:0]) | (data[15:0] & mask[15:0]);
        m_len = (nl == 16'd0) ? 16'd1 : nl;
      end
      4'd3: m_num = (m_num & ~mask) | (data & mask);
      default: ;
    endcase
  endfunction

  // Drives one request cycle (N), observes cycle N+1, then one quiet cycle N+2.
  // Starts and ends 1 time unit after a rising edge.
  task automatic txn(input bit wr, input logic [7:0] waddr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input bit rd, input logic [7:0] raddr,
                     input bit done_p, input bit sent_p);
    x_rdat  = m_read(raddr[5:2]);
    x_start = 1'b0;
    reg_wr_en = wr; reg_wr_addr = waddr; reg_wr_data = wdata; reg_wr_strb = wstrb;
    reg_rd_en = rd; reg_rd_addr = raddr;
    gen_done = done_p; gen_pkt_sent = sent_p;
    if (sent_p && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (wr) m_write(waddr, wdata, wstrb);
    if (done_p) m_done = 1'b1;
    @(posedge clk); #1;
    o_wack = reg_wr_ack; o_rack = reg_rd_ack; o_rdat = reg_rd_data; o_start = gen_start;
    reg_wr_en = 0; reg_rd_en = 0; gen_done = 0; gen_pkt_sent = 0;
    @(posedge clk); #1;
    o_quiet = !reg_wr_ack && !reg_rd_ack && !gen_start;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    n_cmp++; if ({reg_rd_ack, reg_wr_ack, gen_enable, gen_start} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {reg_rd_ack, reg_wr_ack, gen_enable, gen_start}); end
    n_cmp++; if (reg_rd_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_rd_data got %h want 0", reg_rd_data); end
    n_cmp++; if (gen_pkt_len !== 16'd64 || gen_pkt_num !== 32'd1) begin
      n_fail++; $display("FAIL reset_cfg got len %0d num %0d want 64 1", gen_pkt_len, gen_pkt_num); end
    txn(0, 0, 0, 0, 1, 8'h08, 0, 0);
    n_cmp++; if (!o_rack || o_rdat !== 32'd64) begin
      n_fail++; $display("FAIL reset_pkt_len ack %0d data %h want ack 1 data 40", o_rack, o_rdat); end
    txn(0, 0, 0, 0, 1, 8'h0C, 0, 0);
    n_cmp++; if (!o_rack || o_rdat !== 32'd1) begin
      n_fail++; $display("FAIL reset_pkt_num ack %0d data %h want ack 1 data 1", o_rack, o_rdat); end
    txn(0, 0, 0, 0, 1, 8'h10, 0, 0);
    n_cmp++; if (!o_rack || o_rdat !== 32'd0) begin
      n_fail++; $display("FAIL reset_tx_cnt ack %0d data %h want ack 1 data 0", o_rack, o_rdat); end
    txn(0, 0, 0, 0, 1, 8'h14, 0, 0);
    n_cmp++; if (!o_rack || o_rdat !== ID || !o_quiet) begin
      n_fail++; $display("FAIL reset_id ack %0d data %h quiet %0d want ack 1 data %h quiet 1", o_rack, o_rdat, o_quiet, ID); end
  endtask

  task automatic test_byte_strobes();
    txn(1, 8'h08, 32'h0000_1234, 4'b0001, 0, 0, 0, 0);
    n_cmp++; if (!o_wack || gen_pkt_len !== 16'h0034) begin
      n_fail++; $display("FAIL strb_low ack %0d len %h want ack 1 len 0034", o_wack, gen_pkt_len); end
    txn(0, 0, 0, 0, 1, 8'h08, 0, 0);
    n_cmp++; if (o_rdat !== 32'h0000_0034) begin
      n_fail++; $display("FAIL strb_low_rd got %h want 00000034", o_rdat); end
    txn(1, 8'h08, 32'h0000_AB00, 4'b0010, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 1, 8'h08, 0, 0);
    n_cmp++; if (o_rdat !== 32'h0000_AB34) begin
      n_fail++; $display("FAIL strb_high_rd got %h want 0000ab34", o_rdat); end
    txn(1, 8'h08, 32'h0, 4'b1111, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 1, 8'h08, 0, 0);
    n_cmp++; if (o_rdat !== 32'd1) begin
      n_fail++; $display("FAIL len_zero_clamp got %h want 1", o_rdat); end
  endtask

  task automatic test_start();
    gen_busy = 1'b0;
    txn(1, 8'h00, 32'h3, 4'hF, 0, 0, 0, 0);
    n_cmp++; if (!o_wack || !o_start || !o_quiet || !gen_enable) begin
      n_fail++; $display("FAIL start_ok ack %0d start %0d quiet %0d en %0d want 1 1 1 1", o_wack, o_start, o_quiet, gen_enable); end
    gen_busy = 1'b1;
    txn(1, 8'h00, 32'h3, 4'hF, 0, 0, 0, 0);
    n_cmp++; if (o_start) begin
      n_fail++; $display("FAIL start_busy got pulse %0d want 0", o_start); end
    txn(0, 0, 0, 0, 1, 8'h04, 0, 0);
    n_cmp++; if (o_rdat !== 32'h5) begin
      n_fail++; $display("FAIL start_err_status got %h want 5", o_rdat); end
    gen_busy = 1'b0;
    txn(1, 8'h04, 32'h4, 4'h1, 0, 0, 0, 0);
    txn(1, 8'h00, 32'h2, 4'hF, 1, 8'h04, 0, 0);
    n_cmp++; if (o_start || o_rdat !== 32'h0) begin
      n_fail++; $display("FAIL start_disabled pulse %0d status %h want 0 0", o_start, o_rdat); end
    txn(1, 8'h00, 32'h3, 4'b1110, 1, 8'h04, 0, 0);
    n_cmp++; if (o_start || o_rdat !== 32'h4 || gen_enable) begin
      n_fail++; $display("FAIL start_nostrb pulse %0d status %h en %0d want 0 4 0", o_start, o_rdat, gen_enable); end
    txn(1, 8'h04, 32'h4, 4'h1, 0, 0, 0, 0);
  endtask

  task automatic test_done();
    txn(0, 0, 0, 0, 0, 0, 1, 0);
    txn(0, 0, 0, 0, 1, 8'h04, 0, 0);
    n_cmp++; if (o_rdat[1] !== 1'b1) begin
      n_fail++; $display("FAIL done_set got %b want 1", o_rdat[1]); end
    txn(1, 8'h04, 32'h2, 4'h1, 0, 0, 1, 0);
    txn(0, 0, 0, 0, 1, 8'h04, 0, 0);
    n_cmp++; if (o_rdat[1] !== 1'b1) begin
      n_fail++; $display("FAIL done_set_wins got %b want 1", o_rdat[1]); end
    txn(1, 8'h04, 32'h2, 4'h1, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 1, 8'h04, 0, 0);
    n_cmp++; if (o_rdat[1] !== 1'b0) begin
      n_fail++; $display("FAIL done_w1c got %b want 0", o_rdat[1]); end
  endtask

  task automatic test_tx_cnt();
    for (int i = 0; i < 5; i++) txn(0, 0, 0, 0, 0, 0, 0, 1);
    txn(0, 0, 0, 0, 1, 8'h10, 0, 0);
    n_cmp++; if (o_rdat !== 32'd5) begin
      n_fail++; $display("FAIL cnt_five got %0d want 5", o_rdat); end
    txn(1, 8'h00, 32'h4, 4'h1, 0, 0, 0, 1);
    txn(0, 0, 0, 0, 1, 8'h10, 0, 0);
    n_cmp++; if (o_rdat !== 32'd0) begin
      n_fail++; $display("FAIL cnt_clr_wins got %0d want 0", o_rdat); end
    force dut.tx_cnt_q = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.tx_cnt_q;
    m_cnt = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) txn(0, 0, 0, 0, 0, 0, 0, 1);
    txn(0, 0, 0, 0, 1, 8'h10, 0, 1);
    n_cmp++; if (o_rdat !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL cnt_saturate got %h want ffffffff", o_rdat); end
    txn(1, 8'h00, 32'h4, 4'h1, 0, 0, 0, 0);
  endtask

  task automatic test_concurrent();
    txn(1, 8'h0C, 32'hCAFE_0001, 4'hF, 1, 8'h0C, 0, 0);
    n_cmp++; if (!o_wack || !o_rack || o_rdat !== x_rdat) begin
      n_fail++; $display("FAIL rw_same_cycle wack %0d rack %0d data %h want 1 1 %h", o_wack, o_rack, o_rdat, x_rdat); end
    n_cmp++; if (gen_pkt_num !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL rw_new_num got %h want cafe0001", gen_pkt_num); end
  endtask

  task automatic test_mid_reset_unmapped();
    reg_rd_en = 1; reg_rd_addr = 8'h14;
    @(posedge clk); #1;
    rst = 1;
    n_cmp++; if (reg_rd_ack !== 1'b1) begin
      n_fail++; $display("FAIL midrst_first_ack got %0d want 1", reg_rd_ack); end
    @(posedge clk); #1;
    n_cmp++; if (reg_rd_ack !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ack_dropped got %0d want 0", reg_rd_ack); end
    reg_rd_en = 0;
    @(posedge clk); #1;
    rst = 0; m_reset();
    txn(1, 8'h0C, 32'h7, 4'hF, 0, 0, 0, 0);
    reg_rd_en = 1; reg_wr_en = 1; reg_wr_addr = 8'h0C; reg_wr_data = 32'h9; reg_wr_strb = 4'hF; rst = 1;
    @(posedge clk); #1;
    n_cmp++; if (reg_rd_ack !== 1'b0 || reg_wr_ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_with_en rack %0d wack %0d want 0 0", reg_rd_ack, reg_wr_ack); end
    reg_rd_en = 0; reg_wr_en = 0; rst = 0; m_reset();
    @(posedge clk); #1;
    txn(0, 0, 0, 0, 1, 8'h0C, 0, 0);
    n_cmp++; if (o_rdat !== 32'd1) begin
      n_fail++; $display("FAIL rst_restores_num got %h want 1", o_rdat); end
    txn(1, 8'h3C, 32'hFFFF_FFFF, 4'hF, 1, 8'h3C, 0, 0);
    n_cmp++; if (!o_rack || !o_wack || o_rdat !== 32'd0) begin
      n_fail++; $display("FAIL unmapped rack %0d wack %0d data %h want 1 1 0", o_rack, o_wack, o_rdat); end
    txn(0, 0, 0, 0, 1, 8'hC8, 0, 0);
    n_cmp++; if (o_rdat !== 32'd64) begin
      n_fail++; $display("FAIL upper_addr_ignored got %h want 40", o_rdat); end
  endtask

  task automatic test_random();
    bit          wr, rd, dn, st;
    logic [1:0]  up;
    logic [3:0]  wi, ri;
    logic [31:0] d;
    logic [3:0]  s;
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      dn = ($urandom_range(0, 5) == 0); st = ($urandom_range(0, 2) == 0);
      gen_busy = ($urandom_range(0, 3) == 0);
      up = 2'($urandom); wi = 4'($urandom_range(0, 7)); ri = 4'($urandom_range(0, 7));
      d = $urandom; s = 4'($urandom);
      if ($urandom_range(0, 3) == 0) d = d & 32'h0000_00FF;
      txn(wr, {up, wi, 2'b00}, d, s, rd, {~up, ri, 2'b00}, dn, st);
      n_cmp++; if (o_wack !== wr || o_rack !== rd || !o_quiet) begin
        n_fail++; $display("FAIL rnd_ack it %0d wack %0d rack %0d quiet %0d want %0d %0d 1", i, o_wack, o_rack, o_quiet, wr, rd); end
      if (rd) begin
        n_cmp++; if (o_rdat !== x_rdat) begin
          n_fail++; $display("FAIL rnd_rdata it %0d idx %0d got %h want %h", i, ri, o_rdat, x_rdat); end
      end
      n_cmp++; if (o_start !== x_start || gen_enable !== m_en || gen_pkt_len !== m_len || gen_pkt_num !== m_num) begin
        n_fail++; $display("FAIL rnd_outputs it %0d start %0d en %0d len %h num %h want %0d %0d %h %h",
                           i, o_start, gen_enable, gen_pkt_len, gen_pkt_num, x_start, m_en, m_len, m_num); end
    end
    gen_busy = 1'b0;
    for (int r = 0; r < 6; r++) begin
      txn(0, 0, 0, 0, 1, 8'(r * 4), 0, 0);
      n_cmp++; if (o_rdat !== x_rdat) begin
        n_fail++; $display("FAIL rnd_final idx %0d got %h want %h", r, o_rdat, x_rdat); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_byte_strobes();
    test_start();
    test_done();
    test_tx_cnt();
    test_concurrent();
    test_mid_reset_unmapped();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/genaxis_ctrl_regs.md
# genaxis_ctrl_regs

Control/status register bank for the AXI-Stream generator. It sits directly downstream of the AXI-Lite read and write register-interface adapters. It answers their `reg_rd_*` / `reg_wr_*` strobes with single-cycle-latency acks and drives the generator core's configuration and start inputs. It collects the core's busy, done and packet-sent events into readable status and counter registers.

## Interface
- `DATA_WIDTH`, 32, register data width; only 32 is supported.
- `ADDR_WIDTH`, 8, byte address width; decode uses `addr[5:2]`, upper bits are ignored.
- `STRB_WIDTH`, `DATA_WIDTH/8`, write byte-strobe width.
- `ID_VALUE`, 32'h47454E41, constant returned by the ID register.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `reg_wr_addr`  in  ADDR_WIDTH  write byte address.
- `reg_wr_data`  in  DATA_WIDTH  write data.
- `reg_wr_strb`  in  STRB_WIDTH  write byte enables.
- `reg_wr_en`  in  1  write request; held high until acked.
- `reg_wr_wait`  out  1  tied 0.
- `reg_wr_ack`  out  1  one-cycle write acknowledge.
- `reg_rd_addr`  in  ADDR_WIDTH  read byte address.
- `reg_rd_en`  in  1  read request; held high until acked.
- `reg_rd_data`  out  DATA_WIDTH  read data; valid when `reg_rd_ack`=1.
- `reg_rd_wait`  out  1  tied 0.
- `reg_rd_ack`  out  1  one-cycle read acknowledge.
- `gen_enable`  out  1  level; CTRL.enable.
- `gen_start`  out  1  one-cycle start pulse.
- `gen_pkt_len`  out  16  packet length in beats.
- `gen_pkt_num`  out  32  packets per run.
- `gen_busy`  in  1  core is running.
- `gen_done`  in  1  one-cycle pulse at end of run.
- `gen_pkt_sent`  in  1  one-cycle pulse per packet emitted.

## Operation
Register map (byte offsets):
- **0x00 CTRL**
  - bit0 `enable`: RW.
  - bit1 `start`: write-1 pulse, reads 0.
  - bit2 `cnt_clr`: write-1 clears TX_CNT, reads 0.
- **0x04 STATUS**
  - bit0 `busy`: RO, mirrors `gen_busy`.
  - bit1 `done`: sticky, set by `gen_done`, W1C.
  - bit2 `start_err`: sticky, W1C.
- **0x08 PKT_LEN**
  - RW bits[15:0]; bits[31:16] read 0.
  - A written value of 0 is stored as 1.
- **0x0C PKT_NUM**: RW, 32 bits.
- **0x10 TX_CNT**
  - RO; increments on `gen_pkt_sent`.
  - Saturates at 32'hFFFFFFFF.
- **0x14 ID**: RO, returns `ID_VALUE`.
- **Unmapped offsets**: read 0, writes discarded, still acked.

Write rules:
- Byte strobes apply per byte to RW fields.
- A W1C or pulse bit acts only if its byte strobe is set.

Start:
- A write to CTRL with bit1=1 pulses `gen_start` only when all of these hold:
  - the new `enable` (value after this write) is 1;
  - `gen_busy`=0.
- Otherwise no pulse, and `start_err` is set.

## Timing
Reset values:
- `reg_rd_ack`=0, `reg_wr_ack`=0, `reg_rd_data`=0.
- `gen_enable`=0, `gen_start`=0.
- `gen_pkt_len`=64, `gen_pkt_num`=1, TX_CNT=0, `done`=0, `start_err`=0.

Read handshake:
- `reg_rd_ack` and `reg_rd_data` are registered. Condition: `reg_rd_en`=1 and `reg_rd_ack`=0 in cycle N gives ack=1 with data in cycle N+1.
- Ack is never asserted two cycles in a row. The adapter drops en after ack, so exactly one ack is produced per request.
- Data is sampled from the register state in cycle N. A same-cycle TX_CNT increment is not visible.

Write handshake:
- Same rule: `reg_wr_en`=1 and `reg_wr_ack`=0 in cycle N gives `reg_wr_ack`=1 in cycle N+1.
- Register update happens at the edge ending cycle N, so the new value is visible from cycle N+1.
- `gen_start` is high during cycle N+1 only.

Concurrency:
- Read and write may be in flight simultaneously; they are independent.
- A read of a register written in the same cycle returns the old value.

Simultaneous events:
- `gen_done` pulse and a W1C of `done` in the same cycle: set wins, `done`=1.
- `gen_pkt_sent` and `cnt_clr` in the same cycle: clear wins, TX_CNT=0.
- TX_CNT at all-ones plus `gen_pkt_sent`: stays at all-ones.

Reset:
- `rst` mid-transaction drops any pending ack.
- The adapters are reset together with this block, so no orphaned ack is allowed.

Latency:
- Worst-case ack latency is 1 cycle, which stays below the adapter timeout of 4.

## Test plan
- **Reset defaults.** Assert `rst` 2 cycles, then read 0x08, 0x0C, 0x10, 0x14 → 64, 1, 0, 32'h47454E41; each ack is exactly 1 cycle after en.
- **Byte strobes.**
  - Write 0x08 = 32'h0000_1234 with strb=4'b0001 → readback 0x0034.
  - Write 0x08 = 0 → readback 1.
- **Start gating.**
  - Write CTRL=0x3 with `gen_busy`=0 → `gen_start` high for exactly 1 cycle, the cycle after en; `gen_enable`=1.
  - Repeat with `gen_busy`=1 → no pulse; STATUS reads 0x5.
- **Done sticky.**
  - Pulse `gen_done` → STATUS bit1=1.
  - Write STATUS=0x2 coincident with another `gen_done` pulse → bit1 stays 1.
  - Write STATUS=0x2 alone → bit1 becomes 0.
- **TX_CNT.**
  - 5 `gen_pkt_sent` pulses → reads 5.
  - CTRL=0x4 coincident with a pulse → reads 0.
  - Force the count to 32'hFFFFFFFE, then 3 pulses → reads 32'hFFFFFFFF.
- **Mid-transaction reset and unmapped offsets.**
  - Assert `rst` in the cycle after `reg_rd_en` rises → no `reg_rd_ack` in the following cycle.
  - Read 0x3C → data 0, acked.
